// File: rtl/sort_pkg.sv
// Shared definitions for the sequential sorter: state codes, mode codes,
// the slot record and the "must follow" ordering rule.
package sort_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SORT = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    localparam logic MODE_ASC  = 1'b0;
    localparam logic MODE_DESC = 1'b1;

    // Fields are held at a generous fixed width so one rule serves any instance.
    typedef struct packed {
        logic        valid;
        logic [31:0] weight;
        logic [31:0] character;
    } slot_t;

    // True when a must be placed after b.
    function automatic logic must_follow(logic mode, slot_t a, slot_t b);
        logic res;
        if (a.valid != b.valid)
            res = b.valid;
        else if (!a.valid)
            res = 1'b0;
        else if (a.weight != b.weight)
            res = (mode == MODE_ASC) ? (a.weight > b.weight) : (a.weight < b.weight);
        else
            res = (a.character > b.character);
        return res;
    endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Combinational compare/exchange of one adjacent slot pair; lo is the lower
// slot index, hi the higher one.
module sort_cmp_swap
    import sort_pkg::*;
#(
    parameter int W_WEIGHT = 5,
    parameter int W_CHAR   = 4
) (
    input  logic                mode,
    input  logic                lo_valid,
    input  logic [W_WEIGHT-1:0] lo_weight,
    input  logic [W_CHAR-1:0]   lo_character,
    input  logic                hi_valid,
    input  logic [W_WEIGHT-1:0] hi_weight,
    input  logic [W_CHAR-1:0]   hi_character,
    output logic                lo_valid_nxt,
    output logic [W_WEIGHT-1:0] lo_weight_nxt,
    output logic [W_CHAR-1:0]   lo_character_nxt,
    output logic                hi_valid_nxt,
    output logic [W_WEIGHT-1:0] hi_weight_nxt,
    output logic [W_CHAR-1:0]   hi_character_nxt,
    output logic                swapped
);

    slot_t sa, sb;

    always_comb begin
        sa           = '0;
        sa.valid     = lo_valid;
        sa.weight    = 32'(lo_weight);
        sa.character = 32'(lo_character);
        sb           = '0;
        sb.valid     = hi_valid;
        sb.weight    = 32'(hi_weight);
        sb.character = 32'(hi_character);
        swapped      = must_follow(mode, sa, sb);
    end

    assign lo_valid_nxt     = swapped ? hi_valid     : lo_valid;
    assign lo_weight_nxt    = swapped ? hi_weight    : lo_weight;
    assign lo_character_nxt = swapped ? hi_character : lo_character;
    assign hi_valid_nxt     = swapped ? lo_valid     : hi_valid;
    assign hi_weight_nxt    = swapped ? lo_weight    : hi_weight;
    assign hi_character_nxt = swapped ? lo_character : hi_character;

endmodule

// File: rtl/sort_engine_seq.sv
// Burst loader plus odd-even transposition sorter, one phase per clock with
// early exit once two consecutive phases see no exchange.
module sort_engine_seq
    import sort_pkg::*;
#(
    parameter int N        = 8,
    parameter int W_WEIGHT = 5,
    parameter int W_CHAR   = 4,
    parameter int W_CNT    = $clog2(N+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_mode,
    input  logic [W_WEIGHT-1:0]   in_weight,
    input  logic [W_CHAR-1:0]     in_character,
    output logic                  out_valid,
    output logic [N*W_CHAR-1:0]   out_character,
    output logic [N*W_WEIGHT-1:0] out_weight,
    output logic [W_CNT-1:0]      out_count,
    output logic                  busy
);

    logic [1:0]          state;
    logic                mode_q;
    logic [W_CNT-1:0]    count;
    logic [W_CNT-1:0]    phase;
    logic                prev_swap;

    logic [N-1:0]        slot_vld;
    logic [W_WEIGHT-1:0] slot_w [N];
    logic [W_CHAR-1:0]   slot_c [N];

    logic                ev_v [N];
    logic [W_WEIGHT-1:0] ev_w [N];
    logic [W_CHAR-1:0]   ev_c [N];
    logic                ev_swp [N];
    logic                od_v [N];
    logic [W_WEIGHT-1:0] od_w [N];
    logic [W_CHAR-1:0]   od_c [N];
    logic                od_swp [N];

    logic                nxt_v [N];
    logic [W_WEIGHT-1:0] nxt_w [N];
    logic [W_CHAR-1:0]   nxt_c [N];
    logic                phase_swap;
    logic                sort_done;
    logic                sort_step;

    // Even phase: pairs (0,1),(2,3),...
    for (genvar i = 0; i < N/2; i++) begin : g_even
        sort_cmp_swap #(.W_WEIGHT(W_WEIGHT), .W_CHAR(W_CHAR)) u_cs (
            .mode             (mode_q),
            .lo_valid         (slot_vld[2*i]),
            .lo_weight        (slot_w[2*i]),
            .lo_character     (slot_c[2*i]),
            .hi_valid         (slot_vld[2*i+1]),
            .hi_weight        (slot_w[2*i+1]),
            .hi_character     (slot_c[2*i+1]),
            .lo_valid_nxt     (ev_v[2*i]),
            .lo_weight_nxt    (ev_w[2*i]),
            .lo_character_nxt (ev_c[2*i]),
            .hi_valid_nxt     (ev_v[2*i+1]),
            .hi_weight_nxt    (ev_w[2*i+1]),
            .hi_character_nxt (ev_c[2*i+1]),
            .swapped          (ev_swp[i])
        );
    end
    for (genvar i = N/2; i < N; i++) begin : g_even_nc
        assign ev_swp[i] = 1'b0;
    end
    if (N % 2 == 1) begin : g_even_tail
        assign ev_v[N-1] = slot_vld[N-1];
        assign ev_w[N-1] = slot_w[N-1];
        assign ev_c[N-1] = slot_c[N-1];
    end

    // Odd phase: pairs (1,2),(3,4),...; slot 0 always passes through.
    assign od_v[0] = slot_vld[0];
    assign od_w[0] = slot_w[0];
    assign od_c[0] = slot_c[0];
    for (genvar i = 0; i < (N-1)/2; i++) begin : g_odd
        sort_cmp_swap #(.W_WEIGHT(W_WEIGHT), .W_CHAR(W_CHAR)) u_cs (
            .mode             (mode_q),
            .lo_valid         (slot_vld[2*i+1]),
            .lo_weight        (slot_w[2*i+1]),
            .lo_character     (slot_c[2*i+1]),
            .hi_valid         (slot_vld[2*i+2]),
            .hi_weight        (slot_w[2*i+2]),
            .hi_character     (slot_c[2*i+2]),
            .lo_valid_nxt     (od_v[2*i+1]),
            .lo_weight_nxt    (od_w[2*i+1]),
            .lo_character_nxt (od_c[2*i+1]),
            .hi_valid_nxt     (od_v[2*i+2]),
            .hi_weight_nxt    (od_w[2*i+2]),
            .hi_character_nxt (od_c[2*i+2]),
            .swapped          (od_swp[i])
        );
    end
    for (genvar i = (N-1)/2; i < N; i++) begin : g_odd_nc
        assign od_swp[i] = 1'b0;
    end
    if (N % 2 == 0) begin : g_odd_tail
        assign od_v[N-1] = slot_vld[N-1];
        assign od_w[N-1] = slot_w[N-1];
        assign od_c[N-1] = slot_c[N-1];
    end

    always_comb begin
        phase_swap = 1'b0;
        for (int i = 0; i < N; i++) begin
            nxt_v[i]   = phase[0] ? od_v[i] : ev_v[i];
            nxt_w[i]   = phase[0] ? od_w[i] : ev_w[i];
            nxt_c[i]   = phase[0] ? od_c[i] : ev_c[i];
            phase_swap = phase_swap | (phase[0] ? od_swp[i] : ev_swp[i]);
        end
    end

    // The cycle after a short burst's last word is already phase 0, so the
    // LOAD state with in_valid low sorts too.
    assign sort_step = (state == ST_SORT) || (state == ST_LOAD && !in_valid);
    assign sort_done = (phase == W_CNT'(N-1)) ||
                       ((phase != '0) && !phase_swap && !prev_swap);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_ASC;
            count     <= '0;
            phase     <= '0;
            prev_swap <= 1'b0;
            slot_vld  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        slot_w[0]   <= in_weight;
                        slot_c[0]   <= in_character;
                        slot_vld[0] <= 1'b1;
                        mode_q      <= in_mode;
                        count       <= W_CNT'(1);
                        phase       <= '0;
                        prev_swap   <= 1'b0;
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        for (int i = 0; i < N; i++) begin
                            if (count == W_CNT'(i)) begin
                                slot_w[i]   <= in_weight;
                                slot_c[i]   <= in_character;
                                slot_vld[i] <= 1'b1;
                            end
                        end
                        count <= count + W_CNT'(1);
                        if (count == W_CNT'(N-1))
                            state <= ST_SORT;
                    end
                end
                ST_OUT: begin
                    slot_vld <= '0;
                    state    <= ST_IDLE;
                end
                default: ;
            endcase

            if (sort_step) begin
                for (int i = 0; i < N; i++) begin
                    slot_vld[i] <= nxt_v[i];
                    slot_w[i]   <= nxt_w[i];
                    slot_c[i]   <= nxt_c[i];
                end
                prev_swap <= phase_swap;
                phase     <= phase + W_CNT'(1);
                state     <= sort_done ? ST_OUT : ST_SORT;
            end
        end
    end

    always_comb begin
        out_valid     = (state == ST_OUT);
        busy          = (state == ST_SORT) || (state == ST_OUT);
        out_count     = out_valid ? count : '0;
        out_character = '0;
        out_weight    = '0;
        for (int i = 0; i < N; i++) begin
            if (out_valid && slot_vld[i]) begin
                out_character[i*W_CHAR +: W_CHAR]       = slot_c[i];
                out_weight[i*W_WEIGHT +: W_WEIGHT]      = slot_w[i];
            end
        end
    end

endmodule

// File: tb/tb_sort_engine_seq.sv
// Randomized and directed bench for sort_engine_seq against a key-sort model.
module tb_sort_engine_seq;

    localparam int N  = 8;
    localparam int WW = 5;
    localparam int WC = 4;
    localparam int WN = $clog2(N+1);

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_mode;
    logic [WW-1:0]   in_weight;
    logic [WC-1:0]   in_character;
    logic            out_valid;
    logic [N*WC-1:0] out_character;
    logic [N*WW-1:0] out_weight;
    logic [WN-1:0]   out_count;
    logic            busy;

    int checks = 0;
    int errors = 0;

    logic [WW-1:0]   bw [N];
    logic [WC-1:0]   bc [N];
    logic [N*WC-1:0] cap_c;
    logic [N*WW-1:0] cap_w;
    int              cap_lat;

    sort_engine_seq #(.N(N), .W_WEIGHT(WW), .W_CHAR(WC)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_mode       (in_mode),
        .in_weight     (in_weight),
        .in_character  (in_character),
        .out_valid     (out_valid),
        .out_character (out_character),
        .out_weight    (out_weight),
        .out_count     (out_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: order by a single integer key, then pack slot 0 into the LSBs.
    task automatic ref_sort(input int k, input logic mode,
                            output logic [N*WC-1:0] ec, output logic [N*WW-1:0] ew);
        int key [N];
        int idx [N];
        int t;
        for (int i = 0; i < N; i++) begin
            idx[i] = i;
            key[i] = (mode ? (31 - int'(bw[i])) : int'(bw[i])) * 16 + int'(bc[i]);
        end
        for (int i = 0; i < k; i++)
            for (int j = i + 1; j < k; j++)
                if (key[idx[j]] < key[idx[i]]) begin
                    t = idx[i]; idx[i] = idx[j]; idx[j] = t;
                end
        ec = '0;
        ew = '0;
        for (int i = 0; i < k; i++) begin
            ec[i*WC +: WC] = bc[idx[i]];
            ew[i*WW +: WW] = bw[idx[i]];
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " out_char"},  64'(out_character), 64'd0);
        chk({tag, " out_weight"},64'(out_weight), 64'd0);
        chk({tag, " out_count"}, 64'(out_count), 64'd0);
        chk({tag, " busy"},      64'(busy), 64'd0);
    endtask

    // Drives k entries (later entries carry the opposite mode bit), holds
    // in_valid with junk for 'hold' cycles, then checks the result.
    task automatic run_burst(input string tag, input int k, input logic mode,
                             input int hold, input int exp_lat);
        logic [N*WC-1:0] ec;
        logic [N*WW-1:0] ew;
        int lat;
        ref_sort(k, mode, ec, ew);
        for (int i = 0; i < k; i++) begin
            in_valid     = 1'b1;
            in_mode      = (i == 0) ? mode : ~mode;
            in_weight    = bw[i];
            in_character = bc[i];
            @(posedge clk); #1;
        end
        lat = 1;
        while (lat <= 40) begin
            if (lat <= hold) begin
                in_valid     = 1'b1;
                in_mode      = ~mode;
                in_weight    = WW'($urandom);
                in_character = WC'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            if (lat == 2) chk({tag, " busy"}, 64'(busy), 64'd1);
            if (out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        cap_lat  = lat;
        chk({tag, " out_valid seen"}, 64'(out_valid), 64'd1);
        if (out_valid) begin
            cap_c = out_character;
            cap_w = out_weight;
            chk({tag, " chars"},  64'(out_character), 64'(ec));
            chk({tag, " weights"},64'(out_weight), 64'(ew));
            chk({tag, " count"},  64'(out_count), 64'(k));
            if (exp_lat > 0)
                chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
            else
                chk({tag, " latency in 3..N+1"}, 64'(lat >= 3 && lat <= N + 1), 64'd1);
            @(posedge clk); #1;
            check_idle({tag, " post"});
        end
    endtask

    initial begin
        int pulses;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_mode      = 1'b0;
        in_weight    = '0;
        in_character = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed bursts with known results.
        bw = '{5'd3, 5'd7, 5'd3, 5'd1, 5'd9, 5'd0, 5'd7, 5'd2};
        bc = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        run_burst("full asc", 8, 1'b0, 0, 0);
        chk("full asc const", 64'(cap_c), 64'h46120735);
        run_burst("full desc", 8, 1'b1, 0, 0);
        chk("full desc const", 64'(cap_c), 64'h53720614);

        bw[0] = 5'd5; bc[0] = 4'hA;
        bw[1] = 5'd2; bc[1] = 4'hB;
        bw[2] = 5'd5; bc[2] = 4'h3;
        run_burst("partial", 3, 1'b0, 0, 0);
        chk("partial chars const", 64'(cap_c), 64'h00000A3B);
        chk("partial weights const", 64'(cap_w), 64'h14A2);

        bw[0] = 5'd13; bc[0] = 4'd9;
        run_burst("single", 1, 1'b1, 0, 3);
        chk("single slot0", 64'(cap_c), 64'h9);

        for (int i = 0; i < N; i++) begin bw[i] = WW'(i); bc[i] = WC'(i); end
        run_burst("presorted", 8, 1'b0, 0, 3);

        for (int i = 0; i < N; i++) begin bw[i] = WW'(7 - i); bc[i] = WC'(i); end
        run_burst("reverse", 8, 1'b0, 0, 0);
        chk("reverse const", 64'(cap_c), 64'h01234567);

        // Reset during phase 3, with in_valid raised in the reset cycle.
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1; in_mode = 1'b0; in_weight = bw[i]; in_character = bc[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        check_idle("mid-sort reset");
        pulses = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        chk("no pulse after reset", 64'(pulses), 64'd0);

        for (int i = 0; i < N; i++) begin
            bw[i] = WW'($urandom); bc[i] = WC'($urandom);
        end
        run_burst("after reset held", 8, 1'b0, 2, 0);

        // Randomized back-to-back bursts, half with a narrow weight range for ties.
        for (int r = 0; r < 30; r++) begin
            int k;
            k = $urandom_range(1, N);
            for (int i = 0; i < N; i++) begin
                bw[i] = (r % 2 == 0) ? WW'($urandom_range(0, 3)) : WW'($urandom);
                bc[i] = WC'($urandom);
            end
            run_burst($sformatf("rand%0d", r), k, 1'($urandom_range(0, 1)),
                      (k == N) ? int'($urandom_range(0, 2)) : 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
